// File: rtl/color_centroid_finder.sv
// Scans an RGB565 frame held in RAM, two pixels per word, and reports how many
// pixels fall inside an RGB window together with their floor-averaged centroid.
module color_centroid_finder #(
  parameter logic [17:0] FRAME_BASE = 18'd1,
  parameter int          IMG_WIDTH  = 320,
  parameter int          IMG_HEIGHT = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  r_min,
  input  logic [4:0]  r_max,
  input  logic [5:0]  g_min,
  input  logic [5:0]  g_max,
  input  logic [4:0]  b_min,
  input  logic [4:0]  b_max,
  output logic [17:0] address,
  output logic        rden,
  input  logic [31:0] data_read,
  output logic        busy,
  output logic        done,
  output logic [16:0] match_count,
  output logic [8:0]  centroid_x,
  output logic [7:0]  centroid_y,
  output logic        found
);

  localparam int unsigned NWORDS    = (IMG_WIDTH * IMG_HEIGHT) / 2;
  localparam logic [17:0] LAST_WORD = 18'(NWORDS - 1);
  localparam logic [9:0]  X_WRAP    = 10'(IMG_WIDTH);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, DIV_X, DIV_Y, DONE} state_t;

  state_t      state, state_nxt;
  logic [17:0] word_cnt;
  logic        rd_valid;
  logic [8:0]  px;
  logic [7:0]  py;
  logic [16:0] count, count_nxt;
  logic [24:0] sum_x, sum_x_nxt;
  logic [24:0] sum_y, sum_y_nxt;
  logic        m_hi, m_lo;

  logic [24:0] div_q, q_new;
  logic [16:0] div_r, r_new;
  logic [17:0] rem_sh;
  logic        ge;
  logic [4:0]  div_cnt;
  logic [8:0]  qx;

  // Pixel match on the word returned for the previous cycle's read.
  always_comb begin
    m_hi = rd_valid
        && (data_read[31:27] >= r_min) && (data_read[31:27] <= r_max)
        && (data_read[26:21] >= g_min) && (data_read[26:21] <= g_max)
        && (data_read[20:16] >= b_min) && (data_read[20:16] <= b_max);
    m_lo = rd_valid
        && (data_read[15:11] >= r_min) && (data_read[15:11] <= r_max)
        && (data_read[10:5]  >= g_min) && (data_read[10:5]  <= g_max)
        && (data_read[4:0]   >= b_min) && (data_read[4:0]   <= b_max);
  end

  always_comb begin
    count_nxt = count + {16'd0, m_hi} + {16'd0, m_lo};
    sum_x_nxt = sum_x + (m_hi ? {16'd0, px} : '0)
                      + (m_lo ? ({16'd0, px} + 25'd1) : '0);
    sum_y_nxt = sum_y + (m_hi ? {17'd0, py} : '0)
                      + (m_lo ? {17'd0, py} : '0);
  end

  // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh = {div_r, div_q[24]};
    ge     = rem_sh >= {1'b0, count};
    r_new  = ge ? 17'(rem_sh - {1'b0, count}) : rem_sh[16:0];
    q_new  = {div_q[23:0], ge};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = READ;
      READ:  if (word_cnt == LAST_WORD) state_nxt = DRAIN;
      DRAIN: state_nxt = (count_nxt == '0) ? DONE : DIV_X;
      DIV_X: if (div_cnt == 5'd24) state_nxt = DIV_Y;
      DIV_Y: if (div_cnt == 5'd24) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rden    = (state == READ);
    address = rden ? (FRAME_BASE + word_cnt) : '0;
    busy    = (state != IDLE);
    done    = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      word_cnt    <= '0;
      rd_valid    <= 1'b0;
      px          <= '0;
      py          <= '0;
      count       <= '0;
      sum_x       <= '0;
      sum_y       <= '0;
      div_q       <= '0;
      div_r       <= '0;
      div_cnt     <= '0;
      qx          <= '0;
      match_count <= '0;
      centroid_x  <= '0;
      centroid_y  <= '0;
      found       <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_valid <= (state == READ);

      if (rd_valid) begin
        count <= count_nxt;
        sum_x <= sum_x_nxt;
        sum_y <= sum_y_nxt;
        if (({1'b0, px} + 10'd2) >= X_WRAP) begin
          px <= '0;
          py <= py + 8'd1;
        end else begin
          px <= px + 9'd2;
        end
      end

      case (state)
        IDLE: if (start) begin
          word_cnt <= '0;
          px       <= '0;
          py       <= '0;
          count    <= '0;
          sum_x    <= '0;
          sum_y    <= '0;
        end
        READ: word_cnt <= word_cnt + 18'd1;
        DRAIN: begin
          // Final word lands this cycle, so the divider loads the updated sum.
          div_q   <= sum_x_nxt;
          div_r   <= '0;
          div_cnt <= '0;
          if (count_nxt == '0) begin
            match_count <= '0;
            centroid_x  <= '0;
            centroid_y  <= '0;
            found       <= 1'b0;
          end
        end
        DIV_X: begin
          div_q   <= q_new;
          div_r   <= r_new;
          div_cnt <= div_cnt + 5'd1;
          if (div_cnt == 5'd24) begin
            qx      <= q_new[8:0];
            div_q   <= sum_y;
            div_r   <= '0;
            div_cnt <= '0;
          end
        end
        DIV_Y: begin
          div_q   <= q_new;
          div_r   <= r_new;
          div_cnt <= div_cnt + 5'd1;
          if (div_cnt == 5'd24) begin
            match_count <= count;
            centroid_x  <= qx;
            centroid_y  <= q_new[7:0];
            found       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_color_centroid_finder.sv
// Directed bench: a default-size instance for the full-frame case and a small
// 32x24 instance (base 5, 384 words) for the remaining scenarios.
module tb_color_centroid_finder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] r_min, r_max, b_min, b_max;
  logic [5:0] g_min, g_max;

  logic        f_reset, f_start, f_rden, f_busy, f_done, f_found;
  logic [17:0] f_address;
  logic [31:0] f_data;
  logic [16:0] f_match_count;
  logic [8:0]  f_centroid_x;
  logic [7:0]  f_centroid_y;

  logic        s_reset, s_start, s_rden, s_busy, s_done, s_found;
  logic [17:0] s_address;
  logic [31:0] s_data;
  logic [16:0] s_match_count;
  logic [8:0]  s_centroid_x;
  logic [7:0]  s_centroid_y;

  logic [31:0] mem [0:383];

  int total = 0;
  int bad   = 0;

  int first_done, n_done;
  logic [17:0] first_addr;
  logic        first_rden;
  logic [31:0] d_count, d_cx, d_cy, d_found, mid_count, mid_found;

  color_centroid_finder dut_full (
    .clk(clk), .reset(f_reset), .start(f_start),
    .r_min(r_min), .r_max(r_max), .g_min(g_min), .g_max(g_max),
    .b_min(b_min), .b_max(b_max),
    .address(f_address), .rden(f_rden), .data_read(f_data),
    .busy(f_busy), .done(f_done), .match_count(f_match_count),
    .centroid_x(f_centroid_x), .centroid_y(f_centroid_y), .found(f_found)
  );

  color_centroid_finder #(.FRAME_BASE(18'd5), .IMG_WIDTH(32), .IMG_HEIGHT(24)) dut (
    .clk(clk), .reset(s_reset), .start(s_start),
    .r_min(r_min), .r_max(r_max), .g_min(g_min), .g_max(g_max),
    .b_min(b_min), .b_max(b_max),
    .address(s_address), .rden(s_rden), .data_read(s_data),
    .busy(s_busy), .done(s_done), .match_count(s_match_count),
    .centroid_x(s_centroid_x), .centroid_y(s_centroid_y), .found(s_found)
  );

  always @(posedge clk) f_data <= f_rden ? 32'hFFFF_FFFF : 32'h0;

  always @(posedge clk) begin
    int idx;
    idx = int'(s_address) - 5;
    if (s_rden && idx >= 0 && idx < 384) s_data <= mem[idx];
    else s_data <= 32'h0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 384; i++) mem[i] = 32'h0;
  endtask

  task automatic set_win(input logic [4:0] rl, input logic [4:0] rh,
                         input logic [5:0] gl, input logic [5:0] gh,
                         input logic [4:0] bl, input logic [4:0] bh);
    r_min = rl; r_max = rh; g_min = gl; g_max = gh; b_min = bl; b_max = bh;
  endtask

  // Start at cycle 0, then watch 600 cycles; optional extra start / reset cycle.
  task automatic run_small(input int extra_start_at, input int reset_at);
    first_done = -1;
    n_done     = 0;
    @(negedge clk) s_start = 1'b1;
    @(negedge clk) s_start = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      if (c == 1) begin
        first_addr = s_address;
        first_rden = s_rden;
      end
      if (c == 200) begin
        mid_count = 32'(s_match_count);
        mid_found = 32'(s_found);
      end
      if (s_done) begin
        n_done++;
        if (first_done < 0) begin
          first_done = c;
          d_count = 32'(s_match_count);
          d_cx    = 32'(s_centroid_x);
          d_cy    = 32'(s_centroid_y);
          d_found = 32'(s_found);
        end
      end
      s_start = (c + 1 == extra_start_at);
      s_reset = (c + 1 == reset_at);
      @(negedge clk);
    end
    s_start = 1'b0;
    s_reset = 1'b0;
  endtask

  initial begin
    int cyc;
    f_reset = 1'b1; s_reset = 1'b1;
    f_start = 1'b0; s_start = 1'b0;
    set_win(5'd0, 5'd31, 6'd0, 6'd63, 5'd0, 5'd31);
    clear_mem();
    repeat (3) @(negedge clk);
    f_reset = 1'b0; s_reset = 1'b0;
    @(negedge clk);

    chk("rst_address", 32'(s_address), 0);
    chk("rst_rden",    32'(s_rden), 0);
    chk("rst_busy",    32'(s_busy), 0);
    chk("rst_done",    32'(s_done), 0);
    chk("rst_count",   32'(s_match_count), 0);
    chk("rst_cx",      32'(s_centroid_x), 0);
    chk("rst_cy",      32'(s_centroid_y), 0);
    chk("rst_found",   32'(s_found), 0);
    chk("rst_f_busy",  32'(f_busy), 0);

    // Full default-size frame, everything matches.
    f_start = 1'b1;
    @(negedge clk) f_start = 1'b0;
    chk("full_addr0", 32'(f_address), 1);
    chk("full_rden0", 32'(f_rden), 1);
    chk("full_busy",  32'(f_busy), 1);
    cyc = 1;
    while (!f_done && cyc < 40000) begin
      @(negedge clk);
      cyc++;
    end
    chk("full_done_cycle", cyc, 38452);
    chk("full_count", 32'(f_match_count), 76800);
    chk("full_cx",    32'(f_centroid_x), 159);
    chk("full_cy",    32'(f_centroid_y), 119);
    chk("full_found", 32'(f_found), 1);
    @(negedge clk);
    chk("full_done_pulse", 32'(f_done), 0);
    chk("full_idle", 32'(f_busy), 0);
    chk("full_hold_count", 32'(f_match_count), 76800);

    // Two red pixels in word 0 of the small frame.
    clear_mem();
    mem[0] = 32'hF800_F800;
    set_win(5'd31, 5'd31, 6'd0, 6'd0, 5'd0, 5'd0);
    run_small(0, 0);
    chk("red_addr0",  32'(first_addr), 5);
    chk("red_rden0",  32'(first_rden), 1);
    chk("red_done",   first_done, 436);
    chk("red_ndone",  n_done, 1);
    chk("red_count",  d_count, 2);
    chk("red_cx",     d_cx, 0);
    chk("red_cy",     d_cy, 0);
    chk("red_found",  d_found, 1);

    // All-zero frame rejected by r_min=1; previous results hold mid-scan.
    clear_mem();
    set_win(5'd1, 5'd31, 6'd0, 6'd63, 5'd0, 5'd31);
    run_small(0, 0);
    chk("zero_hold_count", mid_count, 2);
    chk("zero_hold_found", mid_found, 1);
    chk("zero_done",  first_done, 386);
    chk("zero_ndone", n_done, 1);
    chk("zero_count", d_count, 0);
    chk("zero_cx",    d_cx, 0);
    chk("zero_cy",    d_cy, 0);
    chk("zero_found", d_found, 0);

    // Green pixels at (3,2) low half and (6,7) high half; floor(9/2)=4; restart at 100 ignored.
    clear_mem();
    mem[33]  = 32'h0000_07E0;
    mem[115] = 32'h07E0_0000;
    set_win(5'd0, 5'd0, 6'd63, 6'd63, 5'd0, 5'd0);
    run_small(100, 0);
    chk("pair_done",  first_done, 436);
    chk("pair_ndone", n_done, 1);
    chk("pair_count", d_count, 2);
    chk("pair_cx",    d_cx, 4);
    chk("pair_cy",    d_cy, 4);

    // Reset mid-scan aborts without done and clears results.
    run_small(0, 50);
    chk("abort_ndone", n_done, 0);
    chk("abort_busy",  32'(s_busy), 0);
    chk("abort_count", 32'(s_match_count), 0);
    chk("abort_found", 32'(s_found), 0);

    // Fresh scan after the abort: single pixel at x=11, y=20.
    clear_mem();
    mem[325] = 32'h0000_07E0;
    run_small(0, 0);
    chk("single_addr0", 32'(first_addr), 5);
    chk("single_done",  first_done, 436);
    chk("single_ndone", n_done, 1);
    chk("single_count", d_count, 1);
    chk("single_cx",    d_cx, 11);
    chk("single_cy",    d_cy, 20);
    chk("single_found", d_found, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
